fft_band_meter: RTL and testbench

- Parametrised successor of the fixed 8-band FFT spectrum counter.
- Consumes the streamed FFT magnitude output, one bin per valid cycle.
- Sums the positive-frequency bins into NUM_BANDS equal-width bands and quantises each band sum against LEVELS runtime-programmable thresholds.
- Drives thermometer-coded bar levels to the WS2812 display driver, plus a per-frame done pulse.

---
 rtl/fft_band_meter_pkg.sv | 28 ++
 rtl/fft_level_quant.sv | 32 +++
 rtl/fft_band_meter.sv | 173 +++++++++++++++++
 tb/tb_fft_band_meter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_band_meter_pkg.sv
// Shared types and helpers for the FFT band meter.
package fft_band_meter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StQuant,
    StDone
  } state_e;

  function automatic int unsigned band_width(int unsigned fft_n, int unsigned num_bands);
    return fft_n / (2 * num_bands);
  endfunction

  function automatic int unsigned idx_width(int unsigned fft_n);
    return (fft_n > 1) ? $clog2(fft_n) : 1;
  endfunction

  // Unsigned add clamped to 2^w-1; callers truncate the result to w bits.
  function automatic logic [63:0] sat_add(logic [63:0] a, logic [63:0] b, int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/fft_level_quant.sv
// Combinational band quantiser: counts thresholds strictly below s and emits
// that many low-order ones.
module fft_level_quant #(
  parameter int unsigned LEVELS = 8,
  parameter int unsigned SUM_W  = 20
) (
  input  logic [SUM_W-1:0]        i_s,
  input  logic [LEVELS*SUM_W-1:0] i_thr,
  output logic [LEVELS-1:0]       o_therm
);

  localparam int unsigned LVL_W = $clog2(LEVELS + 1);

  logic [LVL_W-1:0] w_level;

  always_comb begin
    w_level = '0;
    for (int k = 0; k < int'(LEVELS); k++) begin
      if (i_s > i_thr[k*SUM_W +: SUM_W]) begin
        w_level = w_level + LVL_W'(1);
      end
    end
  end

  always_comb begin
    o_therm = '0;
    for (int k = 0; k < int'(LEVELS); k++) begin
      o_therm[k] = (LVL_W'(k) < w_level);
    end
  end

endmodule

// File: rtl/fft_band_meter.sv
// Streams FFT magnitudes into equal-width band sums and quantises them into
// thermometer bars. Define FFT_BAND_METER_PEAK_DECAY_EN for peak hold with decay.
module fft_band_meter
  import fft_band_meter_pkg::*;
#(
  parameter int unsigned FFT_N        = 1024,
  parameter int unsigned NUM_BANDS    = 8,
  parameter int unsigned LEVELS       = 8,
  parameter int unsigned AMP_W        = 14,
  parameter int unsigned SUM_W        = 20,
  parameter int unsigned SCALE_SH     = 2,
  parameter int unsigned DECAY_FRAMES = 4
) (
  input  logic                          fft_clk,
  input  logic                          rst_n,
  input  logic                          bin_valid,
  input  logic [idx_width(FFT_N)-1:0]   bin_idx,
  input  logic [AMP_W-1:0]              bin_amp,
  input  logic [LEVELS*SUM_W-1:0]       quant_thr,
  output logic [NUM_BANDS*LEVELS-1:0]   bar,
  output logic                          frame_done
);

  localparam int unsigned IDX_W  = idx_width(FFT_N);
  localparam int unsigned HALF   = FFT_N / 2;
  localparam int unsigned BW     = band_width(FFT_N, NUM_BANDS);
  localparam int unsigned BW_SH  = $clog2(BW);
  localparam int unsigned BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  state_e                      r_state, w_state_next;
  logic [SUM_W-1:0]            r_acc [NUM_BANDS];
  logic [BAND_W-1:0]           r_qband;
  logic [NUM_BANDS*LEVELS-1:0] r_bar;

  logic              w_first, w_last, w_in_half, w_clear, w_acc_en, w_qlast;
  logic [BAND_W-1:0] w_band;
  logic [SUM_W-1:0]  w_sum, w_s;
  logic [LEVELS-1:0] w_therm, w_bar_band;

  assign w_in_half = bin_idx < IDX_W'(HALF);
  assign w_first   = bin_valid && (bin_idx == '0);
  assign w_last    = bin_valid && (bin_idx == IDX_W'(HALF - 1));
  assign w_band    = BAND_W'(bin_idx >> BW_SH);
  assign w_sum     = SUM_W'(sat_add(64'(r_acc[w_band]), 64'(bin_amp), SUM_W));
  assign w_clear   = w_first && ((r_state == StIdle) || (r_state == StAcc));
  assign w_acc_en  = bin_valid && w_in_half && (r_state == StAcc);
  assign w_qlast   = (r_qband == BAND_W'(NUM_BANDS - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_first) w_state_next = StAcc;
      StAcc:   if (w_last) w_state_next = StQuant;
      StQuant: if (w_qlast) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A bin 0 seen in IDLE or ACC always starts a fresh frame.
  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < int'(NUM_BANDS); b++) r_acc[b] <= '0;
    end else if (w_clear) begin
      for (int b = 1; b < int'(NUM_BANDS); b++) r_acc[b] <= '0;
      r_acc[0] <= SUM_W'(bin_amp);
    end else if (w_acc_en) begin
      r_acc[w_band] <= w_sum;
    end
  end

  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qband <= '0;
    end else if ((r_state == StQuant) && !w_qlast) begin
      r_qband <= r_qband + BAND_W'(1);
    end else begin
      r_qband <= '0;
    end
  end

  assign w_s = r_acc[r_qband] >> SCALE_SH;

  fft_level_quant #(
    .LEVELS (LEVELS),
    .SUM_W  (SUM_W)
  ) u_quant (
    .i_s     (w_s),
    .i_thr   (quant_thr),
    .o_therm (w_therm)
  );

`ifdef FFT_BAND_METER_PEAK_DECAY_EN
  localparam int unsigned LVL_W  = $clog2(LEVELS + 1);
  localparam int unsigned DCNT_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic [LVL_W-1:0]  r_hold [NUM_BANDS];
  logic [DCNT_W-1:0] r_dcnt [NUM_BANDS];
  logic [LVL_W-1:0]  w_new_level, w_hold_cur, w_hold_next, w_disp_level;
  logic [DCNT_W-1:0] w_dcnt_cur, w_dcnt_next;

  assign w_hold_cur = r_hold[r_qband];
  assign w_dcnt_cur = r_dcnt[r_qband];

  always_comb begin
    w_new_level = '0;
    for (int k = 0; k < int'(LEVELS); k++) begin
      w_new_level = w_new_level + LVL_W'(w_therm[k]);
    end
  end

  // A lower new level can never exceed hold-1, so the decayed hold is shown.
  always_comb begin
    w_hold_next  = w_hold_cur;
    w_dcnt_next  = w_dcnt_cur;
    w_disp_level = w_hold_cur;
    if (w_new_level >= w_hold_cur) begin
      w_hold_next  = w_new_level;
      w_dcnt_next  = '0;
      w_disp_level = w_new_level;
    end else if (w_dcnt_cur == DCNT_W'(DECAY_FRAMES - 1)) begin
      w_hold_next  = w_hold_cur - LVL_W'(1);
      w_dcnt_next  = '0;
      w_disp_level = w_hold_cur - LVL_W'(1);
    end else begin
      w_dcnt_next  = w_dcnt_cur + DCNT_W'(1);
    end
  end

  always_comb begin
    w_bar_band = '0;
    for (int k = 0; k < int'(LEVELS); k++) begin
      w_bar_band[k] = (LVL_W'(k) < w_disp_level);
    end
  end

  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < int'(NUM_BANDS); b++) begin
        r_hold[b] <= '0;
        r_dcnt[b] <= '0;
      end
    end else if (r_state == StQuant) begin
      r_hold[r_qband] <= w_hold_next;
      r_dcnt[r_qband] <= w_dcnt_next;
    end
  end
`else
  assign w_bar_band = w_therm;
`endif

  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar <= '0;
    end else if (r_state == StQuant) begin
      for (int b = 0; b < int'(NUM_BANDS); b++) begin
        if (r_qband == BAND_W'(b)) r_bar[b*LEVELS +: LEVELS] <= w_bar_band;
      end
    end
  end

  assign bar        = r_bar;
  assign frame_done = (r_state == StDone);

endmodule

// File: tb/tb_fft_band_meter.sv
// Self-checking bench for fft_band_meter at default parameters; the peak-decay
// scenario runs only when FFT_BAND_METER_PEAK_DECAY_EN is defined.
module tb_fft_band_meter;

  localparam int NB    = 8;
  localparam int HALF  = 512;
  localparam int SAT   = 1048575;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bin_valid = 1'b0;
  logic [9:0]   bin_idx = '0;
  logic [13:0]  bin_amp = '0;
  logic [159:0] quant_thr;
  logic [63:0]  bar;
  logic         frame_done;

  int          amp_tab [1024];
  int          thr_v [8] = '{20, 50, 100, 300, 600, 1400, 3200, 6400};
  logic [63:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          n_done = 0;

  fft_band_meter dut (
    .fft_clk    (clk),
    .rst_n      (rst_n),
    .bin_valid  (bin_valid),
    .bin_idx    (bin_idx),
    .bin_amp    (bin_amp),
    .quant_thr  (quant_thr),
    .bar        (bar),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) n_done++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Reference: saturated band sums, scaled, counted against the thresholds.
  function automatic logic [63:0] model_bar();
    longint      sum [8];
    longint      s;
    int          lvl;
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) sum[b] = 0;
    for (int i = 0; i < HALF; i++) begin
      sum[i / 64] += amp_tab[i];
      if (sum[i / 64] > SAT) sum[i / 64] = SAT;
    end
    for (int b = 0; b < NB; b++) begin
      s   = sum[b] / 4;
      lvl = 0;
      for (int k = 0; k < 8; k++) if (s > thr_v[k]) lvl++;
      for (int k = 0; k < lvl; k++) r[b*8 + k] = 1'b1;
    end
    return r;
  endfunction

  task automatic do_reset();
    bin_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 1024; i++) amp_tab[i] = 0;
  endtask

  task automatic drive_bins(input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        bin_valid = 1'b0;
      end
      @(negedge clk);
      bin_valid = 1'b1;
      bin_idx   = 10'(i);
      bin_amp   = 14'(amp_tab[i]);
    end
  endtask

  // Returns cycles from the last driven bin to frame_done, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      bin_valid = 1'b0;
      if (frame_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bar !== 64'h0) begin
      errors++;
      $display("FAIL reset_bar: got %h want %h", bar, 64'h0);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", frame_done);
    end
    do_reset();
  endtask

  task automatic test_flat();
    int lat;
    logic [63:0] exp;
    do_reset();
    for (int i = 0; i < 1024; i++) amp_tab[i] = 1;
    exp_q.push_back(model_bar());
    drive_bins(0, HALF - 1, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== NB + 1) begin
      errors++;
      $display("FAIL flat_latency: got %0d want %0d", lat, NB + 1);
    end
    checks++;
    if (bar !== exp) begin
      errors++;
      $display("FAIL flat_bar: got %h want %h", bar, exp);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL flat_pulse_width: got %b want 0", frame_done);
    end
  endtask

  task automatic test_single_bin();
    int lat;
    logic [63:0] exp;
    do_reset();
    clear_tab();
    amp_tab[70] = 8000;
    exp_q.push_back(model_bar());
    drive_bins(0, HALF - 1, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (bar !== exp || bar[15:8] !== 8'h3F) begin
      errors++;
      $display("FAIL single_bin: got %h want %h (band1 3f)", bar, exp);
    end
  endtask

  task automatic test_saturate();
    int lat;
    logic [63:0] exp;
    do_reset();
    clear_tab();
    for (int i = 0; i < 64; i++) amp_tab[i] = 16383;
    exp_q.push_back(model_bar());
    drive_bins(0, HALF - 1, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (bar !== exp || bar[7:0] !== 8'hFF) begin
      errors++;
      $display("FAIL saturate: got %h want %h (band0 ff)", bar, exp);
    end
  endtask

  task automatic test_thresh_equal();
    int lat;
    logic [63:0] exp;
    do_reset();
    clear_tab();
    amp_tab[128] = 400;
    exp_q.push_back(model_bar());
    drive_bins(0, HALF - 1, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (bar !== exp || bar[23:16] !== 8'h03) begin
      errors++;
      $display("FAIL thresh_equal: got %h want %h (band2 03)", bar, exp);
    end
  endtask

  task automatic test_restart();
    int lat;
    int d0;
    logic [63:0] exp;
    do_reset();
    d0 = n_done;
    for (int i = 0; i < 1024; i++) amp_tab[i] = 9000;
    drive_bins(0, 299, 1'b0);
    for (int i = 0; i < 1024; i++) amp_tab[i] = (i / 64) * 20;
    exp_q.push_back(model_bar());
    drive_bins(0, HALF - 1, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    repeat (4) @(negedge clk);
    checks++;
    if (lat !== NB + 1) begin
      errors++;
      $display("FAIL restart_latency: got %0d want %0d", lat, NB + 1);
    end
    checks++;
    if (bar !== exp) begin
      errors++;
      $display("FAIL restart_bar: got %h want %h", bar, exp);
    end
    checks++;
    if (n_done - d0 !== 1) begin
      errors++;
      $display("FAIL restart_done_count: got %0d want 1", n_done - d0);
    end
  endtask

  // Random bins with stalls; mirror bins are interleaved before the last bin.
  task automatic test_stall_mirror();
    int lat;
    logic [63:0] exp;
    do_reset();
    for (int i = 0; i < HALF; i++) amp_tab[i] = $urandom_range(0, 400);
    for (int i = HALF; i < 1024; i++) amp_tab[i] = 16383;
    exp_q.push_back(model_bar());
    drive_bins(0, HALF - 2, 1'b1);
    drive_bins(HALF, 700, 1'b1);
    drive_bins(HALF - 1, HALF - 1, 1'b1);
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== NB + 1) begin
      errors++;
      $display("FAIL stall_latency: got %0d want %0d", lat, NB + 1);
    end
    checks++;
    if (bar !== exp) begin
      errors++;
      $display("FAIL stall_mirror_bar: got %h want %h", bar, exp);
    end
  endtask

  // Bins for the last band keep arriving while bands are being quantised.
  task automatic test_quant_ignore();
    int lat;
    logic [63:0] exp;
    do_reset();
    clear_tab();
    amp_tab[0] = 100;
    exp_q.push_back(model_bar());
    drive_bins(0, HALF - 1, 1'b0);
    for (int c = 0; c < NB; c++) begin
      @(negedge clk);
      bin_valid = 1'b1;
      bin_idx   = 10'd448;
      bin_amp   = 14'd16383;
    end
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL quant_ignore_latency: got %0d want 1", lat);
    end
    checks++;
    if (bar !== exp) begin
      errors++;
      $display("FAIL quant_ignore_bar: got %h want %h", bar, exp);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int d0;
    logic [63:0] exp;
    do_reset();
    for (int i = 0; i < 1024; i++) amp_tab[i] = 16383;
    drive_bins(0, HALF - 1, 1'b0);
    @(negedge clk);
    bin_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bar[7:0] !== 8'hFF) begin
      errors++;
      $display("FAIL mid_quant_band0: got %h want ff", bar[7:0]);
    end
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bar !== 64'h0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got bar %h done %b want 0 0", bar, frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (n_done !== d0) begin
      errors++;
      $display("FAIL mid_reset_no_done: got %0d want %0d", n_done - d0, 0);
    end
    clear_tab();
    amp_tab[200] = 4000;
    exp_q.push_back(model_bar());
    drive_bins(0, HALF - 1, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (bar !== exp || lat !== NB + 1) begin
      errors++;
      $display("FAIL mid_reset_recover: got %h lat %0d want %h lat %0d", bar, lat, exp, NB + 1);
    end
  endtask

`ifdef FFT_BAND_METER_PEAK_DECAY_EN
  task automatic test_decay();
    int lat;
    int lvl;
    logic [63:0] exp;
    do_reset();
    clear_tab();
    amp_tab[192] = 4000;
    exp_q.push_back(64'h1F << 24);
    drive_bins(0, HALF - 1, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (bar !== exp) begin
      errors++;
      $display("FAIL decay_load: got %h want %h", bar, exp);
    end
    clear_tab();
    for (int n = 1; n <= 20; n++) begin
      lvl = 5 - n / 4;
      exp_q.push_back(64'((64'd1 << lvl) - 64'd1) << 24);
      drive_bins(0, HALF - 1, 1'b0);
      wait_done(lat);
      exp = exp_q.pop_front();
      checks++;
      if (bar !== exp) begin
        errors++;
        $display("FAIL decay_frame%0d: got %h want %h", n, bar, exp);
      end
    end
    amp_tab[192] = 4000;
    drive_bins(0, HALF - 1, 1'b0);
    wait_done(lat);
    clear_tab();
    drive_bins(0, HALF - 1, 1'b0);
    @(negedge clk);
    bin_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bar !== 64'h0) begin
      errors++;
      $display("FAIL decay_mid_reset: got %h want 0", bar);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(64'h0);
    drive_bins(0, HALF - 1, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (bar !== exp) begin
      errors++;
      $display("FAIL decay_hold_cleared: got %h want %h", bar, exp);
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 8; k++) quant_thr[k*20 +: 20] = 20'(thr_v[k]);
    clear_tab();
    test_reset();
    test_flat();
    test_single_bin();
    test_saturate();
    test_thresh_equal();
    test_restart();
    test_stall_mirror();
    test_quant_ignore();
    test_reset_mid();
`ifdef FFT_BAND_METER_PEAK_DECAY_EN
    test_decay();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
